// File: rtl/frac_div_pkg.sv
// Shared constants and state encoding for the frac_div17 sequential fractional divider.
package frac_div_pkg;

  localparam int NW   = 17;
  localparam int DW   = 8;
  localparam int FRAC = 7;
  localparam int QI   = NW + FRAC;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [NW-1:0] SAT_POS = 17'h0FFFF;
  localparam logic [NW-1:0] SAT_NEG = 17'h10000;

endpackage

// File: rtl/frac_div_absval.sv
// Two's complement to sign + magnitude; the magnitude is one bit wider so the most negative value fits.
module frac_div_absval #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  output logic         neg,
  output logic [W:0]   mag
);

  assign neg = val[W-1];
  assign mag = neg ? ({1'b0, ~val} + (W+1)'(1)) : {1'b0, val};

endmodule

// File: rtl/frac_div17.sv
// Sequential signed fractional divider: quo = (num << FRAC) / den, restoring, one quotient bit per cycle.
// Optional macro FRAC_DIV_ROUND_EN: round half-up with one extra finalise cycle (default truncates).
module frac_div17
  import frac_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quo,
  output logic          sat,
  output logic          dz
);

  localparam logic [4:0] LAST_IT = 5'(QI);

  state_t        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [QI-1:0] dvd_q, dvd_d;
  logic [9:0]    rem_q, rem_d;
  logic [DW:0]   den_mag_q, den_mag_d;
  logic          sign_q, sign_d;
  logic          nneg_q, nneg_d;
  logic [NW-1:0] quo_q, quo_d;
  logic          sat_q, sat_d;
  logic          dz_q, dz_d;

  logic          num_sign, den_sign;
  logic [NW:0]   num_mag;
  logic [DW:0]   den_mag;
  logic [9:0]    trial;
  logic [QI:0]   m;
  logic [QI:0]   limit;
  logic [1:0]    unused_bits;

  frac_div_absval #(.W(NW)) u_num_abs (.val(num), .neg(num_sign), .mag(num_mag));
  frac_div_absval #(.W(DW)) u_den_abs (.val(den), .neg(den_sign), .mag(den_mag));

  // |num| never exceeds 2^16 and the remainder stays below |den|, so these top bits are always zero.
  assign unused_bits = {num_mag[NW], rem_q[9]};

`ifdef FRAC_DIV_ROUND_EN
  logic round_up;
  assign round_up = {rem_q[8:0], 1'b0} >= {1'b0, den_mag_q};
`endif

  assign trial = {rem_q[8:0], dvd_q[QI-1]};
  assign m     = {1'b0, dvd_q};
  assign limit = sign_q ? (QI+1)'(65536) : (QI+1)'(65535);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    den_mag_d = den_mag_q;
    sign_d    = sign_q;
    nneg_d    = nneg_q;
    quo_d     = quo_q;
    sat_d     = sat_q;
    dz_d      = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = CALC;
          cnt_d     = '0;
          rem_d     = '0;
          dvd_d     = {num_mag[NW-1:0], {FRAC{1'b0}}};
          den_mag_d = den_mag;
          sign_d    = num_sign ^ den_sign;
          nneg_d    = num_sign;
          quo_d     = '0;
          sat_d     = 1'b0;
          dz_d      = 1'b0;
        end
      end
      CALC: begin
        // A zero divisor skips the loop and reports full-scale in the numerator's direction.
        if (den_mag_q == '0) begin
          state_d = DONE;
          quo_d   = nneg_q ? SAT_NEG : SAT_POS;
          sat_d   = 1'b1;
          dz_d    = 1'b1;
        end else if (cnt_q < LAST_IT) begin
          if (trial >= {1'b0, den_mag_q}) begin
            rem_d = trial - {1'b0, den_mag_q};
            dvd_d = {dvd_q[QI-2:0], 1'b1};
          end else begin
            rem_d = trial;
            dvd_d = {dvd_q[QI-2:0], 1'b0};
          end
          cnt_d = cnt_q + 5'd1;
`ifdef FRAC_DIV_ROUND_EN
        end else if (cnt_q == LAST_IT) begin
          dvd_d = dvd_q + QI'(round_up);
          cnt_d = cnt_q + 5'd1;
`endif
        end else begin
          state_d = DONE;
          if (m > limit) begin
            quo_d = sign_q ? SAT_NEG : SAT_POS;
            sat_d = 1'b1;
          end else begin
            quo_d = sign_q ? (~m[NW-1:0] + NW'(1)) : m[NW-1:0];
            sat_d = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      den_mag_q <= '0;
      sign_q    <= 1'b0;
      nneg_q    <= 1'b0;
      quo_q     <= '0;
      sat_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      den_mag_q <= den_mag_d;
      sign_q    <= sign_d;
      nneg_q    <= nneg_d;
      quo_q     <= quo_d;
      sat_q     <= sat_d;
      dz_q      <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quo       = quo_q;
  assign sat       = sat_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_frac_div17.sv
// Self-checking bench for frac_div17: arithmetic reference model plus directed vectors with literal expectations.
module tb_frac_div17;
  import frac_div_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [NW-1:0] num = '0;
  logic [DW-1:0] den = '0;
  logic          in_ready, out_valid, sat, dz;
  logic [NW-1:0] quo;

  int            checks = 0;
  int            errors = 0;
  logic [NW-1:0] exp_quo = '0;
  logic          exp_sat = 1'b0;
  logic          exp_dz = 1'b0;
  logic          mon_en = 1'b0;

  always #5 clk = ~clk;

  frac_div17 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
    .quo(quo), .sat(sat), .dz(dz)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: plain integer division of |num|*128 by |den|, then sign and clamp.
  function automatic void model(input logic [NW-1:0] n, input logic [DW-1:0] d,
                                output logic [NW-1:0] q, output logic s, output logic z,
                                output int lat);
    longint nn, dd, a, b, mag;
    bit neg;
    nn = longint'($signed(n));
    dd = longint'($signed(d));
    if (dd == 0) begin
      z = 1'b1; s = 1'b1; lat = 1;
      q = (nn < 0) ? 17'h10000 : 17'h0FFFF;
    end else begin
      a = ((nn < 0) ? -nn : nn) * 128;
      b = (dd < 0) ? -dd : dd;
      mag = a / b;
      lat = 25;
`ifdef FRAC_DIV_ROUND_EN
      begin
        longint r;
        r = a % b;
        if (2 * r >= b) mag = mag + 1;
        lat = 26;
      end
`endif
      neg = (n[NW-1] != d[DW-1]);
      z = 1'b0;
      if (!neg && mag > 65535) begin q = 17'h0FFFF; s = 1'b1; end
      else if (neg && mag > 65536) begin q = 17'h10000; s = 1'b1; end
      else begin s = 1'b0; q = neg ? NW'(-mag) : NW'(mag); end
    end
  endfunction

  // Every cycle a result is presented it must match the model and hold steady.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid) begin
      check("mon_quo", 32'(quo), 32'(exp_quo));
      check("mon_sat", 32'(sat), 32'(exp_sat));
      check("mon_dz", 32'(dz), 32'(exp_dz));
      check("mon_in_ready", 32'(in_ready), 32'(0));
    end
  end

  task automatic checkOutput(input string name, input logic [NW-1:0] lit_quo,
                             input logic lit_sat, input logic lit_dz);
    check({name, "_quo"}, 32'(quo), 32'(lit_quo));
    check({name, "_sat"}, 32'(sat), 32'(lit_sat));
    check({name, "_dz"}, 32'(dz), 32'(lit_dz));
  endtask

  task automatic applyStimulus(input string name, input logic [NW-1:0] n, input logic [DW-1:0] d,
                               input logic [NW-1:0] lit_quo, input logic lit_sat,
                               input logic lit_dz, input int hold);
    int  lat_exp;
    int  lat;
    int  i;
    bit  seen;
    bit  busy_bad;
    model(n, d, exp_quo, exp_sat, exp_dz, lat_exp);
    @(negedge clk);
    check({name, "_idle_ready"}, 32'(in_ready), 32'(1));
    num = n; den = d; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep in_valid asserted with junk operands; the busy block must ignore them.
    num = NW'($urandom); den = DW'($urandom);
    seen = 1'b0; busy_bad = 1'b0; lat = 0; i = 0;
    while (!seen && i < 60) begin
      i++;
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin seen = 1'b1; lat = i; end
    end
    in_valid = 1'b0;
    check({name, "_busy_in_ready"}, 32'(busy_bad), 32'(0));
    if (!seen) begin
      check({name, "_timeout"}, 32'(0), 32'(1));
      rst_n = 1'b0; #2; rst_n = 1'b1;
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(lat_exp));
      checkOutput(name, lit_quo, lit_sat, lit_dz);
      mon_en = 1'b1;
      repeat (hold) @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      mon_en = 1'b0;
      check({name, "_post_valid"}, 32'(out_valid), 32'(0));
      check({name, "_post_ready"}, 32'(in_ready), 32'(1));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_quo", 32'(quo), 32'(0));
    check("rst_sat", 32'(sat), 32'(0));
    check("rst_dz", 32'(dz), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("pos_half", 17'd1000, 8'd64, 17'h007D0, 1'b0, 1'b0, 0);
    applyStimulus("neg_half", 17'h1FC18, 8'd64, 17'h1F830, 1'b0, 1'b0, 0);
    applyStimulus("neg_one", 17'd1000, 8'h80, 17'h1FC18, 1'b0, 1'b0, 2);
    applyStimulus("sat_pos", 17'd30000, 8'd1, 17'h0FFFF, 1'b1, 1'b0, 0);
    applyStimulus("sat_neg", 17'h18AD0, 8'd1, 17'h10000, 1'b1, 1'b0, 0);
    applyStimulus("div_zero", 17'h1FFFB, 8'd0, 17'h10000, 1'b1, 1'b1, 10);
    applyStimulus("div_zero_pos", 17'd7, 8'd0, 17'h0FFFF, 1'b1, 1'b1, 0);
    applyStimulus("neg_limit", 17'h18000, 8'd64, 17'h10000, 1'b0, 1'b0, 0);
    applyStimulus("min_by_neg", 17'h10000, 8'h80, 17'h0FFFF, 1'b1, 1'b0, 0);
    applyStimulus("zero_neg", 17'd0, 8'h80, 17'h00000, 1'b0, 1'b0, 0);
    applyStimulus("small_neg", 17'h1FFFF, 8'h7F, 17'h1FFFF, 1'b0, 1'b0, 0);
`ifdef FRAC_DIV_ROUND_EN
    applyStimulus("round_100_3", 17'd100, 8'd3, 17'd4267, 1'b0, 1'b0, 0);
`else
    applyStimulus("trunc_100_3", 17'd100, 8'd3, 17'd4266, 1'b0, 1'b0, 0);
`endif

    // Abandon an operation mid-loop; nothing must emerge afterwards.
    @(negedge clk);
    num = 17'd1000; den = 8'd64; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit leak;
      leak = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (out_valid !== 1'b0) leak = 1'b1;
      end
      check("midrst_no_residual", 32'(leak), 32'(0));
    end
    applyStimulus("after_rst", 17'd500, 8'd32, 17'd2000, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
